// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequenced multiplier controller.
// The core consumes one 4-bit multiplier digit per cycle.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int W1_DEF   = 8;
  localparam int CORE_P_W = W1_DEF + DIGIT_W;

  function automatic int digit_count(input int w2);
    return w2 / DIGIT_W;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/response and core-facing signals of the sequenced multiplier.
// master: requesters, response consumer and core; slave: the controller.
interface mult_seq_ctrl_if
  import mult_seq_pkg::*;
#(
  parameter int W1   = 8,
  parameter int W2   = 16,
  parameter int NREQ = 2
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W1-1:0]   req_a;
  logic [NREQ*W2-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [W1+W2-1:0]     rsp_p;
  logic [W1-1:0]        mul_in1;
  logic [DIGIT_W-1:0]   mul_in2;
  logic [W1+DIGIT_W-1:0] mul_p;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_p,
    input  req_ready, rsp_valid, rsp_id, rsp_p, mul_in1, mul_in2, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_p,
    output req_ready, rsp_valid, rsp_id, rsp_p, mul_in1, mul_in2, busy
  );

endinterface

// File: rtl/mult_rr_arb.sv
// Round-robin arbiter: grant is the first valid requester at or after the
// pointer, wrapping; the pointer advances past the winner on upd_en.
module mult_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic            upd_en,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_valid
);

  logic [ID_W-1:0] ptr_reg;

  assign any_valid = |req_valid;

  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    grant_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_reg) + off) % NREQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh
      assign grant_oh[gi] = any_valid && (grant_idx == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (upd_en) begin
      if (grant_idx == ID_W'(NREQ - 1)) begin
        ptr_reg <= '0;
      end else begin
        ptr_reg <= grant_idx + ID_W'(1);
      end
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shares one W1 x 4 combinational multiplier core among NREQ requesters,
// stepping through the multiplier one digit per cycle and shift-accumulating.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int W1   = 8,
  parameter int W2   = 16,
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  mult_seq_ctrl_if.slave bus
);

  localparam int ND    = digit_count(W2);
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DIG_W = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW    = W1 + W2;

  state_t          state_reg;
  logic [W1-1:0]   a_reg;
  logic [W2-1:0]   b_reg;
  logic [ID_W-1:0] id_reg;
  logic [PW-1:0]   acc_reg;
  logic [DIG_W-1:0] digit_reg;
  logic            rsp_valid_reg;
  logic [PW-1:0]   rsp_p_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic            busy_reg;

  logic [NREQ-1:0] grant_oh;
  logic [ID_W-1:0] grant_idx;
  logic            any_valid;
  logic            req_fire;
  logic            run;

  logic [W1-1:0]   a_slice [NREQ];
  logic [W2-1:0]   b_slice [NREQ];
  logic [DIGIT_W-1:0] digit_val;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   acc_sum;

  assign req_fire = (state_reg == ST_IDLE) && any_valid;
  assign run      = (state_reg == ST_RUN);

  mult_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .upd_en    (req_fire),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_slice[gi] = bus.req_a[gi*W1 +: W1];
      assign b_slice[gi] = bus.req_b[gi*W2 +: W2];
    end
  endgenerate

  assign bus.req_ready = (state_reg == ST_IDLE) ? grant_oh : '0;

  // Core operands are forced to zero outside RUN so the core sees no toggling.
  assign digit_val   = DIGIT_W'(b_reg >> (DIGIT_W * int'(digit_reg)));
  assign bus.mul_in1 = run ? a_reg : '0;
  assign bus.mul_in2 = run ? digit_val : '0;

  assign partial = PW'(bus.mul_p) << (DIGIT_W * int'(digit_reg));
  assign acc_sum = acc_reg + partial;

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_p     = rsp_p_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.busy      = busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= '0;
      acc_reg       <= '0;
      digit_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_p_reg     <= '0;
      rsp_id_reg    <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_valid) begin
            a_reg     <= a_slice[grant_idx];
            b_reg     <= b_slice[grant_idx];
            id_reg    <= grant_idx;
            acc_reg   <= '0;
            digit_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_sum;
          if (digit_reg == DIG_W'(ND - 1)) begin
            rsp_valid_reg <= 1'b1;
            rsp_p_reg     <= acc_sum;
            rsp_id_reg    <= id_reg;
            state_reg     <= ST_DONE;
          end else begin
            digit_reg <= digit_reg + DIG_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl with a behavioural 8x4 core.
module tb_mult_seq_ctrl;
  import mult_seq_pkg::*;

  localparam int W1   = 8;
  localparam int W2   = 16;
  localparam int NREQ = 2;
  localparam int ND   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.W1(W1), .W2(W2), .NREQ(NREQ)) bus ();

  mult_seq_ctrl #(.W1(W1), .W2(W2), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mul_p = 12'(bus.mul_in1) * 12'(bus.mul_in2);

  typedef struct packed {
    logic [0:0]  id;
    logic [23:0] p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and wait for its handshake; returns in the first RUN cycle.
  task automatic send_req(input int i, input logic [7:0] a, input logic [15:0] b);
    int   cnt;
    exp_t e;
    cnt = 0;
    bus.req_a[i*W1 +: W1] = a;
    bus.req_b[i*W2 +: W2] = b;
    bus.req_valid[i]      = 1'b1;
    #1;
    while (!bus.req_ready[i] && cnt < 40) begin
      tick();
      #1;
      cnt++;
    end
    if (cnt >= 40) begin
      check_eq("req_grant_timeout", 64'(cnt), 64'(0));
      bus.req_valid[i] = 1'b0;
      return;
    end
    e.id = 1'(i);
    e.p  = 24'(a) * 24'(b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  // Called in the first RUN cycle: ND busy cycles, then DONE.
  task automatic check_latency();
    for (int k = 0; k < ND; k++) begin
      check_eq("run_no_rsp", 64'(bus.rsp_valid), 64'(0));
      tick();
    end
    check_eq("rsp_latency", 64'(bus.rsp_valid), 64'(1));
    check_eq("done_in1_zero", 64'(bus.mul_in1), 64'(0));
    check_eq("done_in2_zero", 64'(bus.mul_in2), 64'(0));
  endtask

  task automatic get_rsp();
    int   cnt;
    exp_t e;
    cnt = 0;
    while (!bus.rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    if (cnt >= 40) begin
      check_eq("rsp_timeout", 64'(cnt), 64'(0));
      return;
    end
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'(bus.rsp_valid), 64'(0));
      return;
    end
    e = sb.pop_front();
    check_eq("rsp_id", 64'(bus.rsp_id), 64'(e.id));
    check_eq("rsp_p", 64'(bus.rsp_p), 64'(e.p));
    $display("rsp id=%0d p=%06h expected id=%0d p=%06h", bus.rsp_id, bus.rsp_p, e.id, e.p);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("idle_after_rsp", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int          cnt;
    int          gi;
    exp_t        e;
    logic [3:0]  dig_exp [ND];
    int          rr_exp  [3];
    logic [7:0]  rr_a    [2];
    logic [15:0] rr_b    [2];
    logic [23:0] hold_p;
    logic        hold_id;

    dig_exp = '{4'h4, 4'h3, 4'h0, 4'h0};
    rr_exp  = '{0, 1, 0};
    rr_a    = '{8'h5A, 8'hC3};
    rr_b    = '{16'h1234, 16'hBEEF};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_rsp_p", 64'(bus.rsp_p), 64'(0));
    check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check_eq("rst_in1", 64'(bus.mul_in1), 64'(0));
    rst = 1'b0;
    tick();
    check_eq("idle_in2_zero", 64'(bus.mul_in2), 64'(0));

    // Basic product with digit sequence
    send_req(0, 8'h12, 16'h0034);
    for (int k = 0; k < ND; k++) begin
      check_eq("digit_seq", 64'(bus.mul_in2), 64'(dig_exp[k]));
      check_eq("run_in1", 64'(bus.mul_in1), 64'(8'h12));
      check_eq("run_busy", 64'(bus.busy), 64'(1));
      check_eq("run_no_rsp", 64'(bus.rsp_valid), 64'(0));
      tick();
    end
    check_eq("rsp_latency", 64'(bus.rsp_valid), 64'(1));
    check_eq("basic_const", 64'(bus.rsp_p), 64'(24'h0003A8));
    get_rsp();

    // Extreme operands
    send_req(0, 8'hFF, 16'hFFFF);
    check_latency();
    check_eq("max_const", 64'(bus.rsp_p), 64'(24'hFEFF01));
    get_rsp();
    send_req(1, 8'h00, 16'hFFFF);
    check_latency();
    get_rsp();

    // Round-robin from reset with both requesters continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req_a[i*W1 +: W1] = rr_a[i];
      bus.req_b[i*W2 +: W2] = rr_b[i];
    end
    bus.req_valid = 2'b11;
    for (int n = 0; n < 3; n++) begin
      cnt = 0;
      #1;
      while (bus.req_ready == '0 && cnt < 40) begin
        tick();
        #1;
        cnt++;
      end
      check_eq("rr_wait", 64'(cnt), 64'(0));
      check_eq("rr_onehot", 64'($countones(bus.req_ready)), 64'(1));
      gi = bus.req_ready[1] ? 1 : 0;
      check_eq("rr_grant", 64'(gi), 64'(rr_exp[n]));
      e.id = 1'(gi);
      e.p  = 24'(rr_a[gi]) * 24'(rr_b[gi]);
      sb.push_back(e);
      tick();
      check_eq("ready_while_busy", 64'(bus.req_ready), 64'(0));
      get_rsp();
    end
    bus.req_valid = '0;

    // Response backpressure with a pending request
    send_req(0, 8'h77, 16'h4321);
    bus.req_a[1*W1 +: W1] = 8'h09;
    bus.req_b[1*W2 +: W2] = 16'h0102;
    bus.req_valid[1]      = 1'b1;
    cnt = 0;
    while (!bus.rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("bp_rsp_seen", 64'(bus.rsp_valid), 64'(1));
    hold_p  = 24'h77 * 24'h4321;
    hold_id = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_eq("bp_valid", 64'(bus.rsp_valid), 64'(1));
      check_eq("bp_p", 64'(bus.rsp_p), 64'(hold_p));
      check_eq("bp_id", 64'(bus.rsp_id), 64'(hold_id));
      check_eq("bp_req_ready", 64'(bus.req_ready), 64'(0));
      tick();
    end
    get_rsp();
    #1;
    check_eq("grant_after_release", 64'(bus.req_ready), 64'(2'b10));
    send_req(1, 8'h09, 16'h0102);
    check_latency();
    get_rsp();

    // Reset during the second RUN cycle
    send_req(0, 8'h33, 16'h5555);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check_eq("rst_mid_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_mid_in1", 64'(bus.mul_in1), 64'(0));
    bus.req_a[0*W1 +: W1] = 8'h21;
    bus.req_b[0*W2 +: W2] = 16'h0F0F;
    bus.req_valid         = 2'b11;
    #1;
    check_eq("rr_after_reset", 64'(bus.req_ready), 64'(2'b01));
    send_req(0, 8'h21, 16'h0F0F);
    check_latency();
    get_rsp();
    bus.req_valid = '0;

    // Operands change right after the handshake
    send_req(1, 8'hA5, 16'h00F0);
    bus.req_a[1*W1 +: W1] = 8'h11;
    bus.req_b[1*W2 +: W2] = 16'hFFFF;
    check_latency();
    get_rsp();
    check_eq("idle_in1_zero", 64'(bus.mul_in1), 64'(0));
    check_eq("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
